// File: rtl/mtm_alu_serializer.sv
// mtm_Alu output stage: frames one core result as 11-bit serial frames on sout.
// Define MTM_SER_HOLD_EN to add a one-entry holding register for results arriving while busy.
module mtm_alu_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic [31:0] C_in,
    input  logic [3:0]  flags_in,
    input  logic [5:0]  err_flg_in,
    output logic        busy,
    output logic        sout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        TYPE  = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] c_q;
    logic [3:0]  flags_q;
    logic [5:0]  err_q;
    logic [2:0]  frame_cnt;
    logic [2:0]  bit_cnt;
    logic        load;
    logic        last;
    logic        bit_out;
    logic [31:0] ld_c;
    logic [3:0]  ld_f;
    logic [5:0]  ld_e;
    logic [7:0]  frame_byte;
    logic [7:0]  ctl_byte;
    logic [2:0]  crc3;
    logic        par;

`ifdef MTM_SER_HOLD_EN
    logic        hold_vld;
    logic [41:0] hold_q;
`endif

    // CRC-3, x^3+x+1, init 0, over {C, 1'b0, flags} MSB first
    function automatic logic [2:0] crc3_f(input logic [36:0] m);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ m[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    assign crc3     = crc3_f({c_q, 1'b0, flags_q});
    assign par      = ^{1'b1, err_q};
    assign last     = (frame_cnt == 3'd4);
    assign busy     = (state != IDLE);
    assign ctl_byte = (err_q != 6'd0) ? {1'b1, err_q, par}
                                      : {1'b0, flags_q, crc3};

    always_comb begin
        frame_byte = ctl_byte;
        case (frame_cnt)
            3'd0:    frame_byte = c_q[31:24];
            3'd1:    frame_byte = c_q[23:16];
            3'd2:    frame_byte = c_q[15:8];
            3'd3:    frame_byte = c_q[7:0];
            default: frame_byte = ctl_byte;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        bit_out   = 1'b1;
        ld_c      = C_in;
        ld_f      = flags_in;
        ld_e      = err_flg_in;
        unique case (state)
            IDLE: begin
                if (rdy_in) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                bit_out   = 1'b0;
                state_nxt = TYPE;
            end
            TYPE: begin
                bit_out   = last;
                state_nxt = DATA;
            end
            DATA: begin
                bit_out = frame_byte[bit_cnt];
                if (bit_cnt == 3'd0)
                    state_nxt = STOP;
            end
            STOP: begin
                if (!last) begin
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
`ifdef MTM_SER_HOLD_EN
                    if (hold_vld) begin
                        load               = 1'b1;
                        {ld_c, ld_f, ld_e} = hold_q;
                        state_nxt          = START;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                bit_out   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sout  <= 1'b1;
        end else begin
            state <= state_nxt;
            sout  <= bit_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q       <= '0;
            flags_q   <= '0;
            err_q     <= '0;
            frame_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            if (load) begin
                c_q       <= ld_c;
                flags_q   <= ld_f;
                err_q     <= ld_e;
                frame_cnt <= (ld_e != 6'd0) ? 3'd4 : 3'd0;
            end else if (state == STOP && !last) begin
                frame_cnt <= frame_cnt + 3'd1;
            end
            if (state == TYPE)
                bit_cnt <= 3'd7;
            else if (state == DATA)
                bit_cnt <= bit_cnt - 3'd1;
        end
    end

`ifdef MTM_SER_HOLD_EN
    // a result arriving on the consume edge replaces the one being consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld <= 1'b0;
            hold_q   <= '0;
        end else if (busy && rdy_in) begin
            hold_vld <= 1'b1;
            hold_q   <= {C_in, flags_in, err_flg_in};
        end else if (load && state == STOP) begin
            hold_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer against a bit-stream reference model.
// Honours MTM_SER_HOLD_EN for the back-to-back scenario.
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic [31:0] C_in;
    logic [3:0]  flags_in;
    logic [5:0]  err_flg_in;
    logic        busy;
    logic        sout;

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_q[$];
`ifdef MTM_SER_HOLD_EN
    bit hold_en = 1'b1;
`else
    bit hold_en = 1'b0;
`endif

    always #5 clk = ~clk;

    mtm_alu_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .C_in       (C_in),
        .flags_in   (flags_in),
        .err_flg_in (err_flg_in),
        .busy       (busy),
        .sout       (sout)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Remainder of polynomial long division: {C,0,flags} * x^3 mod (x^3+x+1)
    function automatic logic [2:0] gold_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] v;
        v = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i])
                v = v ^ (40'hB << (i - 3));
        return v[2:0];
    endfunction

    function automatic void push_frame(input bit t, input logic [7:0] b);
        exp_q.push_back(1'b0);
        exp_q.push_back(t);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
    endfunction

    function automatic void build(input logic [31:0] c, input logic [3:0] f,
                                  input logic [5:0] e);
        logic [7:0] b;
        logic       p;
        exp_q.delete();
        if (e != 6'd0) begin
            p = ($countones({1'b1, e}) % 2) == 1;
            push_frame(1'b1, {1'b1, e, p});
        end else begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((c >> (24 - 8 * k)) & 32'hFF);
                push_frame(1'b0, b);
            end
            push_frame(1'b1, {1'b0, f, gold_crc(c, f)});
        end
    endfunction

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_sout", sout, 1'b1);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    // Called just after a negedge. inj_at/rst_at < 0 disables those events.
    task automatic send(input logic [31:0] c, input logic [3:0] f, input logic [5:0] e,
                        input int inj_at, input logic [31:0] c2, input logic [3:0] f2,
                        input logic [5:0] e2, input int rst_at);
        int  len;
        bit  two;
        bit  aborted;
        two     = hold_en && (inj_at >= 0);
        aborted = 1'b0;
        build(c, f, e);
        len        = exp_q.size();
        C_in       = c;
        flags_in   = f;
        err_flg_in = e;
        rdy_in     = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_sout", sout, 1'b1);
        C_in       = $urandom;
        flags_in   = 4'($urandom);
        err_flg_in = 6'($urandom);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                check("rst_sout", sout, 1'b1);
                check("rst_busy", busy, 1'b0);
                @(negedge clk);
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
            check("sout", sout, exp_q[i]);
            check("busy", busy, (i + 1 < len) || two);
            if (i == inj_at) begin
                C_in       = c2;
                flags_in   = f2;
                err_flg_in = e2;
                rdy_in     = 1'b1;
            end else begin
                rdy_in = 1'b0;
            end
        end
        rdy_in = 1'b0;
        if (two && !aborted) begin
            build(c2, f2, e2);
            len = exp_q.size();
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                check("sout2", sout, exp_q[i]);
                check("busy2", busy, i + 1 < len);
            end
        end
        idle_check(2);
    endtask

    initial begin
        logic [31:0] rc;
        logic [3:0]  rf;
        logic [5:0]  re;
        rst        = 1'b0;
        rdy_in     = 1'b0;
        C_in       = '0;
        flags_in   = '0;
        err_flg_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_sout", sout, 1'b1);
            check("rst_hold_busy", busy, 1'b0);
            rdy_in = ~rdy_in;
        end
        rdy_in = 1'b0;
        rst    = 1'b1;
        idle_check(2);

        send(32'h0, 4'h0, 6'h0, -1, 32'h0, 4'h0, 6'h0, -1);
        send(32'hA5A5_A5A5, 4'b0010, 6'h0, -1, 32'h0, 4'h0, 6'h0, -1);
        send(32'hFFFF_FFFF, 4'hF, 6'b100100, -1, 32'h0, 4'h0, 6'h0, -1);
        send(32'h1234_5678, 4'h9, 6'h0, 20, 32'hDEAD_BEEF, 4'h3, 6'h0, -1);

        for (int n = 0; n < 8; n++) begin
            rc = $urandom;
            rf = 4'($urandom);
            re = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            send(rc, rf, re, -1, 32'h0, 4'h0, 6'h0, -1);
        end

        send(32'h0, 4'h0, 6'h0, -1, 32'h0, 4'h0, 6'h0, 30);
        rc = $urandom;
        rf = 4'($urandom);
        send(rc, rf, 6'h0, -1, 32'h0, 4'h0, 6'h0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
